// File: rtl/mbist_mem_scheduler.sv
// mbist_mem_scheduler: sequences an MBIST engine over the enabled memories, one at a time,
// and collects per-memory fail and timeout results.
module mbist_mem_scheduler #(
  parameter int MEM_NUM = 4,
  parameter int TO_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic [MEM_NUM-1:0] i_mem_en,
  input  logic [TO_W-1:0]    i_timeout,
  input  logic               i_clear,
  input  logic               i_engine_done,
  input  logic               i_fail,
  output logic [MEM_NUM-1:0] o_mem_sel,
  output logic               o_engine_start,
  output logic               o_engine_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic [MEM_NUM-1:0] o_fail_map,
  output logic [MEM_NUM-1:0] o_timeout_map
);
  localparam int IW = MEM_NUM > 1 ? $clog2(MEM_NUM) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [MEM_NUM-1:0] pend, cur, rem;
  logic [TO_W-1:0] cnt;
  logic accept, timed_out;
  function automatic logic [IW-1:0] lowest(input logic [MEM_NUM-1:0] v);
    lowest = '0;
    for (int i = MEM_NUM - 1; i >= 0; i--)
      if (v[i]) lowest = IW'(i);
  endfunction
  assign cur = MEM_NUM'(1) << idx;
  assign rem = pend & ~cur;
  assign accept = i_start && (state == IDLE || state == DONE);
  // done has priority over an expiring timeout in the same cycle
  assign timed_out = state == WAIT && i_timeout != '0 && cnt == i_timeout && !i_engine_done;
  assign o_mem_sel = (state == SELECT || state == LAUNCH || state == WAIT) ? cur : '0;
  assign o_engine_start = state == LAUNCH;
  assign o_engine_abort = timed_out;
  assign o_busy = !(state == IDLE || state == DONE);
  assign o_done = state == DONE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? (i_mem_en != '0 ? SELECT : DONE) :
                             (state == DONE && i_clear) ? IDLE : state;
      SELECT:     state_nx = LAUNCH;
      LAUNCH:     state_nx = WAIT;
      WAIT:       state_nx = (i_engine_done || timed_out) ? NEXT : WAIT;
      NEXT:       state_nx = rem != '0 ? SELECT : DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      idx <= '0;
      pend <= '0;
      cnt <= '0;
      o_fail_map <= '0;
      o_timeout_map <= '0;
    end else if (accept) begin
      pend <= i_mem_en;
      idx <= lowest(i_mem_en);
      o_fail_map <= '0;
      o_timeout_map <= '0;
    end else if (state == DONE && i_clear) begin
      o_fail_map <= '0;
      o_timeout_map <= '0;
    end else begin
      case (state)
        LAUNCH: cnt <= '0;
        WAIT:
          if (i_engine_done) o_fail_map[idx] <= i_fail;
          else if (timed_out) begin
            o_fail_map[idx] <= 1'b1;
            o_timeout_map[idx] <= 1'b1;
          end else if (cnt != '1) cnt <= cnt + 1'b1;
        NEXT: begin
          pend <= rem;
          idx <= lowest(rem);
        end
        default: ;
      endcase
    end
endmodule
